// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - OAM DMA sequencer: FF46-triggered 160-byte copy into OAM, one byte per M-cycle.
// Optional: define OAM_DMA_ECHO_MIRROR_EN to fold E0-FF source pages onto C0-DF.
module oam_dma_controller #(
  parameter int BYTES           = 160,
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic [7:0]  ff46_rdata,
  output logic        dma_active,
  output logic        cpu_block,
  output logic [15:0] src_addr,
  output logic        src_read_req,
  input  logic [7:0]  src_rdata,
  output logic [7:0]  oam_waddr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we
);

  localparam int TW       = $clog2(CYCLES_PER_BYTE);
  localparam int DLY      = START_DELAY * CYCLES_PER_BYTE;
  localparam int DW       = $clog2(DLY + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CYCLES_PER_BYTE - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(DLY - 1);
  localparam logic [7:0]    IDX_LAST  = 8'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t        state, state_n;
  logic [7:0]    base, base_n;
  logic [7:0]    idx, idx_n;
  logic [TW-1:0] tick, tick_n;
  logic [DW-1:0] dly, dly_n;
  logic [7:0]    byte_q, byte_n;
  logic [7:0]    src_page;
  logic          trigger;

  assign trigger = cpu_write_en && (cpu_addr == 16'hFF46);

`ifdef OAM_DMA_ECHO_MIRROR_EN
  assign src_page = (base >= 8'hE0) ? base - 8'h20 : base;
`else
  assign src_page = base;
`endif

  // FF46 reads always return the page as written, never the mirrored page.
  assign ff46_rdata = (cpu_read_en && cpu_addr == 16'hFF46) ? base : 8'hFF;
  assign dma_active = (state != IDLE);
  assign cpu_block  = (state == XFER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      base   <= 8'h00;
      idx    <= 8'h00;
      tick   <= '0;
      dly    <= '0;
      byte_q <= 8'h00;
    end else begin
      state  <= state_n;
      base   <= base_n;
      idx    <= idx_n;
      tick   <= tick_n;
      dly    <= dly_n;
      byte_q <= byte_n;
    end
  end

  always_comb begin
    state_n      = state;
    base_n       = base;
    idx_n        = idx;
    tick_n       = tick;
    dly_n        = dly;
    byte_n       = byte_q;
    src_read_req = 1'b0;
    src_addr     = 16'h0000;
    oam_we       = 1'b0;
    oam_waddr    = 8'h00;
    oam_wdata    = 8'h00;

    case (state)
      IDLE: begin
        tick_n = '0;
      end
      START: begin
        tick_n = (tick == TICK_LAST) ? '0 : tick + 1'b1;
        if (dly == DLY_LAST) begin
          state_n = XFER;
          tick_n  = '0;
          idx_n   = 8'h00;
          dly_n   = '0;
        end else begin
          dly_n = dly + 1'b1;
        end
      end
      XFER: begin
        tick_n = (tick == TICK_LAST) ? '0 : tick + 1'b1;
        if (tick == '0) begin
          src_read_req = 1'b1;
          src_addr     = {src_page, idx};
          byte_n       = src_rdata;
        end
        // Write phase: last tick of the M-cycle; idx wraps to 0 rather than passing BYTES-1.
        if (tick == TICK_LAST) begin
          oam_we    = 1'b1;
          oam_waddr = idx;
          oam_wdata = byte_q;
          if (idx == IDX_LAST) begin
            state_n = IDLE;
            idx_n   = 8'h00;
          end else begin
            idx_n = idx + 8'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // A trigger restarts from any state and overrides completion.
    if (trigger) begin
      base_n  = cpu_wdata;
      state_n = START;
      tick_n  = '0;
      idx_n   = 8'h00;
      dly_n   = '0;
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - self-checking bench for oam_dma_controller against a cycle-offset model.
// Honours OAM_DMA_ECHO_MIRROR_EN for the expected source page.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_write_en = 1'b0;
  logic        cpu_read_en = 1'b0;
  logic [7:0]  ff46_rdata;
  logic        dma_active;
  logic        cpu_block;
  logic [15:0] src_addr;
  logic        src_read_req;
  logic [7:0]  src_rdata;
  logic [7:0]  oam_waddr;
  logic [7:0]  oam_wdata;
  logic        oam_we;

  oam_dma_controller dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en), .ff46_rdata(ff46_rdata),
    .dma_active(dma_active), .cpu_block(cpu_block), .src_addr(src_addr),
    .src_read_req(src_read_req), .src_rdata(src_rdata), .oam_waddr(oam_waddr),
    .oam_wdata(oam_wdata), .oam_we(oam_we)
  );

  always #5 clk = ~clk;

  // Source memory contents: a fixed hash of the address so every page differs.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] page_of(input logic [7:0] b);
`ifdef OAM_DMA_ECHO_MIRROR_EN
    return (b >= 8'hE0) ? b - 8'h20 : b;
`else
    return b;
`endif
  endfunction

  assign src_rdata = mem_f(src_addr);

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_T = 0;
  bit m_active = 1'b0;
  logic [7:0] m_base = 8'h00;
  int we_cnt = 0;
  logic [7:0] oam_mem [0:255];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: a transfer is a trigger cycle T plus a base; everything follows from the offset cyc-T.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      m_active = 1'b0;
      m_base   = 8'h00;
    end else if (cpu_write_en && cpu_addr == 16'hFF46) begin
      m_active = 1'b1;
      m_T      = cyc;
      m_base   = cpu_wdata;
    end
  end

  always @(posedge reset) begin
    m_active = 1'b0;
    m_base   = 8'h00;
  end

  int  k, n, ph;
  bit  e_act, e_xfer;
  logic [15:0] e_src;
  always @(negedge clk) begin
    k      = cyc - m_T;
    e_act  = m_active && (k < 4 * (1 + 160));
    e_xfer = e_act && (k >= 4);
    n      = (k - 4) / 4;
    ph     = (k - 4) % 4;
    e_src  = {page_of(m_base), 8'(n)};
    check("dma_active", 32'(dma_active), 32'(e_act));
    check("cpu_block", 32'(cpu_block), 32'(e_xfer));
    check("src_read_req", 32'(src_read_req), 32'(e_xfer && ph == 0));
    check("oam_we", 32'(oam_we), 32'(e_xfer && ph == 3));
    if (e_xfer && ph == 0) check("src_addr", 32'(src_addr), 32'(e_src));
    if (e_xfer && ph == 3) begin
      check("oam_waddr", 32'(oam_waddr), 32'(n));
      check("oam_wdata", 32'(oam_wdata), 32'(mem_f(e_src)));
    end
    check("ff46_rdata", 32'(ff46_rdata),
          32'((cpu_read_en && cpu_addr == 16'hFF46) ? m_base : 8'hFF));
    if (oam_we) begin
      oam_mem[oam_waddr] = oam_wdata;
      we_cnt++;
    end
  end

  task automatic goto(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_addr = a; cpu_wdata = d; cpu_write_en = 1'b1;
    @(posedge clk); #1;
    cpu_write_en = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic read_check(input logic [15:0] a, input logic [7:0] exp, input string name);
    @(posedge clk); #1;
    cpu_addr = a; cpu_read_en = 1'b1;
    @(negedge clk);
    check(name, 32'(ff46_rdata), 32'(exp));
    @(posedge clk); #1;
    cpu_read_en = 1'b0; cpu_addr = 16'h0000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t, t3, sel;
  logic [15:0] e5;
  initial begin
    repeat (3) @(negedge clk);
    check("rst dma_active", 32'(dma_active), 32'd0);
    check("rst src_read_req", 32'(src_read_req), 32'd0);
    check("rst oam_we", 32'(oam_we), 32'd0);
    check("rst src_addr", 32'(src_addr), 32'd0);
    check("rst oam_waddr", 32'(oam_waddr), 32'd0);
    check("rst oam_wdata", 32'(oam_wdata), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // Basic transfer from C100
    do_write(16'hFF46, 8'hC1); t = cyc;
    goto(t + 1); check("t1 active T+1", 32'(dma_active), 32'd1);
    check("t1 block T+1", 32'(cpu_block), 32'd0);
    goto(t + 3); check("t1 block T+3", 32'(cpu_block), 32'd0);
    goto(t + 4); check("t1 first req", 32'(src_read_req), 32'd1);
    check("t1 first src", 32'(src_addr), 32'h0000C100);
    check("t1 block T+4", 32'(cpu_block), 32'd1);
    goto(t + 7); check("t1 first we", 32'(oam_we), 32'd1);
    check("t1 first waddr", 32'(oam_waddr), 32'd0);
    read_check(16'hFF46, 8'hC1, "t2 ff46 during");
    read_check(16'hFF47, 8'hFF, "t2 ff47");
    goto(t + 640); check("t1 last src", 32'(src_addr), 32'h0000C19F);
    goto(t + 643); check("t1 last we", 32'(oam_we), 32'd1);
    check("t1 last waddr", 32'(oam_waddr), 32'h9F);
    check("t1 last wdata", 32'(oam_wdata), 32'(mem_f(16'hC19F)));
    goto(t + 644); check("t1 done active", 32'(dma_active), 32'd0);
    check("t1 done block", 32'(cpu_block), 32'd0);
    for (int i = 0; i < 160; i++) check("t1 oam", 32'(oam_mem[i]), 32'(mem_f(16'hC100 + 16'(i))));
    read_check(16'hFF46, 8'hC1, "t2 ff46 after");

    // Restart mid-transfer, then restart on the last-byte edge
    do_write(16'hFF46, 8'h80); t = cyc;
    goto(t + 98);
    do_write(16'hFF46, 8'h90);
    goto(t + 107); check("t3 restart we", 32'(oam_we), 32'd1);
    check("t3 restart waddr", 32'(oam_waddr), 32'd0);
    check("t3 restart wdata", 32'(oam_wdata), 32'(mem_f(16'h9000)));
    goto(t + 742);
    @(posedge clk); #1;
    cpu_addr = 16'hFF46; cpu_wdata = 8'h95; cpu_write_en = 1'b1;
    @(negedge clk);
    check("t3 last we", 32'(oam_we), 32'd1);
    check("t3 last waddr", 32'(oam_waddr), 32'h9F);
    check("t3 last wdata", 32'(oam_wdata), 32'(mem_f(16'h909F)));
    @(posedge clk); #1;
    cpu_write_en = 1'b0; cpu_addr = 16'h0000; t3 = cyc;
    goto(t3); check("t3 edge restart active", 32'(dma_active), 32'd1);
    goto(t3 + 4); check("t3 edge restart src", 32'(src_addr), 32'h00009500);
    goto(t3 + 645);

    // Echo page source
    do_write(16'hFF46, 8'hE2); t = cyc;
`ifdef OAM_DMA_ECHO_MIRROR_EN
    e5 = 16'hC200;
`else
    e5 = 16'hE200;
`endif
    goto(t + 4); check("t5 echo src", 32'(src_addr), 32'(e5));
    read_check(16'hFF46, 8'hE2, "t5 ff46");
    goto(t + 645);

    // Reset in the middle of byte 50
    do_write(16'hFF46, 8'h47); t = cyc;
    goto(t + 204); check("t6 idx50 src", 32'(src_addr), 32'h00004732);
    @(posedge clk); #1;
    reset = 1'b1; cpu_read_en = 1'b1; cpu_addr = 16'hFF46;
    #1;
    check("t6 rst active", 32'(dma_active), 32'd0);
    check("t6 rst we", 32'(oam_we), 32'd0);
    check("t6 rst req", 32'(src_read_req), 32'd0);
    check("t6 rst ff46", 32'(ff46_rdata), 32'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; cpu_read_en = 1'b0; cpu_addr = 16'h0000;
    we_cnt = 0;
    repeat (60) @(negedge clk);
    check("t6 no writes", 32'(we_cnt), 32'd0);

    // Random traffic: reads, stray writes and occasional FF46 triggers
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      sel          = $urandom_range(0, 3);
      cpu_addr     = (sel == 0) ? 16'hFF46 : (sel == 1) ? 16'hFF47 : 16'($urandom);
      cpu_wdata    = 8'($urandom);
      cpu_read_en  = 1'($urandom_range(0, 1));
      cpu_write_en = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1;
    cpu_write_en = 1'b0; cpu_read_en = 1'b0; cpu_addr = 16'h0000;
    repeat (700) @(posedge clk);
    @(negedge clk);
    check("final idle", 32'(dma_active), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
Sequences OAM DMA. A CPU write to FF46 starts a copy of 160 bytes from source page {FF46, 8'h00} into OAM FE00-FE9F, one byte per M-cycle (4 dots). The block sits beside the PPU and owns address FF46, which the PPU register decode excludes. It drives the PPU's OAM write port and the system source-read port, and tells the bus fabric when the CPU must be locked out of non-HRAM space.

Parameters:
- BYTES, 160: bytes per transfer.
- CYCLES_PER_BYTE, 4: clk cycles per transferred byte, which is one M-cycle.
- START_DELAY, 1: M-cycles between the FF46 write and the first source read.

Ports:
- clk  in  1  system clock, one dot per cycle.
- reset  in  1  asynchronous, active-high.
- cpu_addr  in  16  CPU bus address.
- cpu_wdata  in  8  CPU write data.
- cpu_write_en  in  1  CPU write strobe.
- cpu_read_en  in  1  CPU read strobe.
- ff46_rdata  out  8  read data for FF46; combinational.
- dma_active  out  1  high in START or XFER.
- cpu_block  out  1  high in XFER only; the fabric returns FF for CPU non-HRAM reads and drops CPU non-HRAM writes.
- src_addr  out  16  source read address.
- src_read_req  out  1  source read strobe.
- src_rdata  in  8  source data, combinational, valid in the same cycle as src_read_req.
- oam_waddr  out  8  OAM byte index, 0-159.
- oam_wdata  out  8  OAM write data.
- oam_we  out  1  OAM write strobe; has priority over CPU OAM writes.

Behaviour:
- Clock and reset:
  - Clock is clk.
  - reset is asynchronous, active-high.
  - Reset values: state=IDLE, base=8'h00, idx=0, tick=0, byte_q=8'h00. All strobes low. src_addr=0, oam_waddr=0, oam_wdata=0.
- Trigger:
  - A trigger is cpu_write_en && cpu_addr==16'hFF46, sampled at posedge.
  - On a trigger: base<=cpu_wdata, state<=START, tick<=0, idx<=0.
- Restart:
  - A trigger in START or XFER aborts the current copy and restarts it the same way.
  - Bytes already written are not undone.
  - dma_active stays high with no low gap.
- FF46 reads:
  - ff46_rdata = base when cpu_read_en && cpu_addr==16'hFF46, else 8'hFF.
  - Reads never affect state.
- tick counter:
  - tick is a 2-bit counter (log2 CYCLES_PER_BYTE) that wraps CYCLES_PER_BYTE-1 -> 0 in START and XFER.
  - tick is held at 0 in IDLE.
- START state:
  - Lasts START_DELAY*CYCLES_PER_BYTE cycles, counted by a delay counter.
  - Then goes to XFER with tick=0, idx=0.
- XFER state, per byte:
  - tick==0: src_read_req=1, src_addr={src_page, idx}. byte_q<=src_rdata at posedge.
  - tick==CYCLES_PER_BYTE-1: oam_we=1, oam_waddr=idx, oam_wdata=byte_q. Then idx<=idx+1.
  - If idx==BYTES-1 at that write, state<=IDLE at the same posedge, unless a trigger is sampled in the same cycle, in which case the restart wins.
- Strobe decoding: all strobes are decoded combinationally from registered state, tick and idx. Outside their defined cycles, src_read_req=0 and oam_we=0.
- Latency:
  - Trigger posedge at T gives first src_read_req in cycle T+START_DELAY*4 and first oam_we in cycle T+START_DELAY*4+3.
  - The last oam_we is in cycle T+4*(START_DELAY+BYTES)-1. With defaults that is T+643.
  - dma_active deasserts after that last oam_we cycle.
- cpu_block: high in every XFER cycle, low in START and IDLE.
- Width rules:
  - idx is 8-bit and never exceeds BYTES-1.
  - src_addr low byte is idx directly; no carry into the page.

Optional Feature:
Macro: OAM_DMA_ECHO_MIRROR_EN.
- Defined: src_page = (base >= 8'hE0) ? base - 8'h20 : base. This maps E000-FFFF sources onto WRAM C000-DFFF.
- Undefined: src_page = base unmodified. The fabric then decodes E0-FF pages itself.
- ff46_rdata returns the unmodified base in both builds.

Test Plan:
1. Reset, then write FF46=8'hC1 at T. Expect:
   - dma_active=1 from T+1.
   - First src_read_req at T+4 with src_addr=C100.
   - First oam_we at T+7 with oam_waddr=00.
   - Last oam_we at T+643 with oam_waddr=9F, src_addr of that byte C19F.
   - dma_active=0 at T+644.
   - OAM contents equal C100-C19F.
2. Read FF46 during and after test 1 -> ff46_rdata=C1. Read FF47 -> 8'hFF.
3. Write FF46=8'h80 at T, then FF46=8'h90 at T+100. Expect:
   - dma_active continuously high.
   - Next oam_we at oam_waddr=00 with data from 9000, at T+107.
   - Completion at T+743.
4. Check cpu_block: 0 during T+1..T+3, 1 during T+4..T+643, 0 afterwards.
5. Write FF46=8'hE2. Expect:
   - With OAM_DMA_ECHO_MIRROR_EN: first src_addr=C200.
   - Without it: E200.
   - ff46_rdata=E2 in both builds.
6. Assert reset mid-XFER at idx=50. Expect:
   - Immediately dma_active=0, oam_we=0, src_read_req=0, ff46_rdata on read = 8'h00.
   - No further OAM writes after reset deasserts until a new FF46 write.
